unlock_arbiter: RTL and testbench

UNLOCK_ARBITER -- requirements
Module: unlock_arbiter

---
 rtl/unlock_arbiter.sv | 145 ++++++++++++++
 tb/tb_unlock_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/unlock_arbiter.sv
// Round-robin arbiter draining per-core thread-unlock requests to the serializer.
// Optional grant/contention counters: define UNLOCK_ARBITER_STATS_EN.
module unlock_arbiter #(
  parameter int N_CORES  = 8,
  parameter int THREAD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CORES-1:0]           core_valid,
  input  logic [N_CORES*THREAD_W-1:0]  core_thread,
  input  logic [N_CORES-1:0]           core_finish,
  output logic [N_CORES-1:0]           core_ready,
  input  logic                         arb_enable,
  output logic                         unlock_valid,
  output logic [THREAD_W-1:0]          unlock_thread,
  output logic                         finish_task,
  output logic                         idle,
  output logic [31:0]                  stat_grants,
  output logic [31:0]                  stat_contention
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [N_CORES-1:0]  pend_v;
  logic [N_CORES-1:0]  pend_finish;
  logic [THREAD_W-1:0] pend_thread [N_CORES];

  logic [N_CORES-1:0]  grant;
  logic [N_CORES-1:0]  accept;
  logic                grant_any;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       rr_next;

  // First pending entry at or after rr_ptr, wrapping
  always_comb begin
    int            idx;
    logic [PW-1:0] sel;
    idx       = 0;
    sel       = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (arb_enable) begin
      for (int k = 0; k < N_CORES; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CORES) begin
          idx = idx - N_CORES;
        end
        sel = PW'(idx);
        if (!grant_any && pend_v[sel]) begin
          grant_any  = 1'b1;
          grant[sel] = 1'b1;
          grant_idx  = sel;
        end
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      if (int'(grant_idx) == N_CORES - 1) begin
        rr_next = '0;
      end else begin
        rr_next = grant_idx + 1'b1;
      end
    end
  end

  assign core_ready = ~pend_v | grant;
  assign accept     = core_valid & core_ready;
  assign idle       = (pend_v == '0) & ~unlock_valid;

  // Capture wins over grant so an entry refills on the edge it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v      <= '0;
      pend_finish <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        pend_thread[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (accept[i]) begin
          pend_v[i]      <= 1'b1;
          pend_finish[i] <= core_finish[i];
          pend_thread[i] <= core_thread[i*THREAD_W +: THREAD_W];
        end else if (grant[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      unlock_valid  <= 1'b0;
      finish_task   <= 1'b0;
      unlock_thread <= '0;
    end else begin
      rr_ptr       <= rr_next;
      unlock_valid <= grant_any;
      finish_task  <= grant_any & pend_finish[grant_idx];
      if (grant_any) begin
        unlock_thread <= pend_thread[grant_idx];
      end
    end
  end

`ifdef UNLOCK_ARBITER_STATS_EN
  logic [PW:0]  n_pend;
  logic [31:0]  grants_q;
  logic [31:0]  contention_q;

  always_comb begin
    n_pend = '0;
    for (int i = 0; i < N_CORES; i++) begin
      n_pend = n_pend + {{PW{1'b0}}, pend_v[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q     <= '0;
      contention_q <= '0;
    end else begin
      if (grant_any) begin
        grants_q <= grants_q + 32'd1;
      end
      if (n_pend > (PW+1)'(1)) begin
        contention_q <= contention_q + 32'd1;
      end
    end
  end

  assign stat_grants     = grants_q;
  assign stat_contention = contention_q;
`else
  assign stat_grants     = '0;
  assign stat_contention = '0;
`endif

endmodule

// File: tb/tb_unlock_arbiter.sv
// Directed bench for unlock_arbiter: vector table plus reset and
// long-stream sequences; stats expectations follow UNLOCK_ARBITER_STATS_EN.
module tb_unlock_arbiter;

`ifdef UNLOCK_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  core_valid;
  logic [31:0] core_thread;
  logic [7:0]  core_finish;
  logic [7:0]  core_ready;
  logic        arb_enable;
  logic        unlock_valid;
  logic [3:0]  unlock_thread;
  logic        finish_task;
  logic        idle;
  logic [31:0] stat_grants;
  logic [31:0] stat_contention;

  unlock_arbiter #(.N_CORES(8), .THREAD_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_valid      (core_valid),
    .core_thread     (core_thread),
    .core_finish     (core_finish),
    .core_ready      (core_ready),
    .arb_enable      (arb_enable),
    .unlock_valid    (unlock_valid),
    .unlock_thread   (unlock_thread),
    .finish_task     (finish_task),
    .idle            (idle),
    .stat_grants     (stat_grants),
    .stat_contention (stat_contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic [31:0] th;
    logic [7:0]  f;
    logic        en;
    logic        uv;
    logic [3:0]  ut;
    logic        uf;
    logic [7:0]  rdy;
    logic        id;
  } vec_t;

  vec_t tbl[$];
  int   errors;
  int   checks;

  function automatic void add(logic [7:0] v, logic [31:0] th, logic [7:0] f,
                              logic en, logic uv, logic [3:0] ut, logic uf,
                              logic [7:0] rdy, logic id);
    vec_t e;
    e.v = v; e.th = th; e.f = f; e.en = en;
    e.uv = uv; e.ut = ut; e.uf = uf; e.rdy = rdy; e.id = id;
    tbl.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int pulses;
  int bad_fin;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    core_valid = '0;
    core_thread = '0;
    core_finish = '0;
    arb_enable = 1'b1;

    // single request, core 3 thread 5 finish
    add(8'h08, 32'h0000_5000, 8'h08, 1, 0, 4'h0, 0, 8'hFF, 1);
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'h0, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h5, 1, 8'hFF, 0);
    // core 0 moves rr_ptr to 1
    add(8'h01, 32'h0000_0002, 8'h00, 1, 0, 4'h5, 0, 8'hFF, 1);
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'h5, 0, 8'hFF, 0);
    // burst on cores 0,1,2 -> order 1,2,0
    add(8'h07, 32'h0000_0987, 8'h02, 1, 1, 4'h2, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'h2, 0, 8'hFA, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h8, 1, 8'hFE, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h9, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h7, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'h7, 0, 8'hFF, 1);
    // core 4 streaming four requests
    add(8'h10, 32'h0001_0000, 8'h00, 1, 0, 4'h7, 0, 8'hFF, 1);
    add(8'h10, 32'h0002_0000, 8'h00, 1, 0, 4'h7, 0, 8'hFF, 0);
    add(8'h10, 32'h0003_0000, 8'h00, 1, 1, 4'h1, 0, 8'hFF, 0);
    add(8'h10, 32'h0004_0000, 8'h00, 1, 1, 4'h2, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h3, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'h4, 0, 8'hFF, 0);
    // hold with cores 0 and 7 pending
    add(8'h81, 32'hB000_000A, 8'h80, 0, 0, 4'h4, 0, 8'hFF, 1);
    for (int k = 0; k < 10; k++) begin
      add(8'h00, 32'h0, 8'h00, 0, 0, 4'h4, 0, 8'h7E, 0);
    end
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'h4, 0, 8'hFE, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'hB, 1, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 1, 4'hA, 0, 8'hFF, 0);
    add(8'h00, 32'h0, 8'h00, 1, 0, 4'hA, 0, 8'hFF, 1);

    #2;
    chk("rst uv", 32'(unlock_valid), 32'h0);
    chk("rst ready", 32'(core_ready), 32'hFF);
    #20;
    rst = 1'b0;
    #1;
    chk("post-rst idle", 32'(idle), 32'h1);
    chk("post-rst thread", 32'(unlock_thread), 32'h0);
    chk("post-rst grants", stat_grants, 32'h0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      core_valid  = tbl[i].v;
      core_thread = tbl[i].th;
      core_finish = tbl[i].f;
      arb_enable  = tbl[i].en;
      #1;
      chk($sformatf("v%0d uv", i), 32'(unlock_valid), 32'(tbl[i].uv));
      chk($sformatf("v%0d thread", i), 32'(unlock_thread), 32'(tbl[i].ut));
      chk($sformatf("v%0d finish", i), 32'(finish_task), 32'(tbl[i].uf));
      chk($sformatf("v%0d ready", i), 32'(core_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d idle", i), 32'(idle), 32'(tbl[i].id));
      if (i == 10) begin
        chk("burst grants", stat_grants, STATS ? 32'd5 : 32'd0);
        chk("burst contention", stat_contention, STATS ? 32'd2 : 32'd0);
      end
      if (i == 31) begin
        chk("hold grants", stat_grants, STATS ? 32'd11 : 32'd0);
        chk("hold contention", stat_contention, STATS ? 32'd13 : 32'd0);
      end
    end

    // reset with three entries pending
    @(posedge clk);
    #1;
    core_valid  = 8'h0E;
    core_thread = 32'h0000_3210;
    core_finish = 8'h0E;
    arb_enable  = 1'b0;
    @(posedge clk);
    #1;
    core_valid = '0;
    #1;
    chk("pre-rst ready", 32'(core_ready), 32'hF1);
    rst = 1'b1;
    #1;
    chk("mid-rst idle", 32'(idle), 32'h1);
    chk("mid-rst ready", 32'(core_ready), 32'hFF);
    chk("mid-rst grants", stat_grants, 32'h0);
    chk("mid-rst contention", stat_contention, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    arb_enable = 1'b1;
    #1;
    chk("release ready", 32'(core_ready), 32'hFF);
    chk("release idle", 32'(idle), 32'h1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2;
      if (unlock_valid) pulses++;
    end
    chk("no pulse after rst", 32'(pulses), 32'h0);
    chk("idle after rst", 32'(idle), 32'h1);

    // 100 grants from core 0
    pulses = 0;
    bad_fin = 0;
    for (int k = 0; k < 105; k++) begin
      @(posedge clk);
      #1;
      core_valid  = (k < 100) ? 8'h01 : 8'h00;
      core_thread = 32'(k[3:0]);
      core_finish = 8'(k[0]);
      #1;
      if (unlock_valid) pulses++;
      if (finish_task && !unlock_valid) bad_fin++;
    end
    chk("stream pulses", 32'(pulses), 32'd100);
    chk("finish w/o unlock", 32'(bad_fin), 32'd0);
    chk("stream grants", stat_grants, STATS ? 32'd100 : 32'd0);
    chk("stream contention", stat_contention, 32'd0);
    chk("stream idle", 32'(idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
